// File: rtl/cc_pkg.sv
// -----------------------------------------------------------------------------
// cc_pkg
// Shared definitions for the base-delta-immediate (BDI) cache line compressor:
// encoding codes, element/delta widths (in bytes) and payload sizes (in bits)
// for every BxDk class, plus the pack/unpack helpers used by the compressor
// and by the bdi_decompress sub-module.
// Configuration macro: CC_ZERO_REP_EN (consumed by compressor_unit only).
// -----------------------------------------------------------------------------
package cc_pkg;

    localparam int LINE_W     = 256;
    localparam int LINE_BYTES = LINE_W / 8;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [3:0] {
        ENC_ZEROS  = 4'd0,
        ENC_REP8   = 4'd1,
        ENC_B8D1   = 4'd2,
        ENC_B4D1   = 4'd3,
        ENC_B8D2   = 4'd4,
        ENC_B2D1   = 4'd5,
        ENC_B4D2   = 4'd6,
        ENC_B8D4   = 4'd7,
        ENC_UNCOMP = 4'd15
    } enc_e;

    // Element (base) width X and delta width K, both in bytes.
    localparam int B8D1_X = 8, B8D1_K = 1;
    localparam int B4D1_X = 4, B4D1_K = 1;
    localparam int B8D2_X = 8, B8D2_K = 2;
    localparam int B2D1_X = 2, B2D1_K = 1;
    localparam int B4D2_X = 4, B4D2_K = 2;
    localparam int B8D4_X = 8, B8D4_K = 4;

    // Payload size in bits: 8X + (32/X) * 8K.
    localparam int B8D1_BITS = 96;
    localparam int B4D1_BITS = 96;
    localparam int B8D2_BITS = 128;
    localparam int B2D1_BITS = 144;
    localparam int B4D2_BITS = 160;
    localparam int B8D4_BITS = 192;

    typedef struct packed {
        logic  fit;
        line_t payload;
    } bdi_t;

    // Low mask covering 'bytes' bytes of a 64-bit word.
    function automatic logic [63:0] lo_mask(input int bytes);
        return (bytes >= 8) ? '1 : ((64'd1 << (8 * bytes)) - 64'd1);
    endfunction

    // Sign-extend the low 'bytes' bytes of v to 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] v, input int bytes);
        logic [63:0] m;
        m = lo_mask(bytes);
        return (((v >> (8 * bytes - 1)) & 64'd1) != 64'd0) ? (v | ~m) : (v & m);
    endfunction

    // Try to encode a line as BxDk. Element 0 is the base; a delta fits when
    // its x-byte signed value survives truncation to k bytes unchanged.
    function automatic bdi_t bdi_pack(input line_t line, input int x, input int k);
        bdi_t        r;
        logic [63:0] mx;
        logic [63:0] base;
        logic [63:0] e;
        logic [63:0] d;
        mx         = lo_mask(x);
        base       = line[63:0] & mx;
        r.fit      = 1'b1;
        r.payload  = '0;
        r.payload[63:0] = base;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (i < LINE_BYTES / x) begin
                e = 64'(line >> (8 * x * i)) & mx;
                d = (e - base) & mx;
                if (sext(d, x) != sext(d & lo_mask(k), k)) r.fit = 1'b0;
                r.payload = r.payload | (line_t'(d & lo_mask(k)) << (8 * x + 8 * k * i));
            end
        end
        return r;
    endfunction

    // Rebuild a line from a BxDk payload: element_i = base + sext(delta_i).
    function automatic line_t bdi_unpack(input line_t comp, input int x, input int k);
        line_t       out;
        logic [63:0] mx;
        logic [63:0] base;
        logic [63:0] d;
        logic [63:0] e;
        mx   = lo_mask(x);
        base = comp[63:0] & mx;
        out  = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (i < LINE_BYTES / x) begin
                d   = 64'(comp >> (8 * x + 8 * k * i)) & lo_mask(k);
                e   = (base + sext(d, k)) & mx;
                out = out | (line_t'(e) << (8 * x * i));
            end
        end
        return out;
    endfunction

endpackage

// File: rtl/bdi_decompress.sv
// -----------------------------------------------------------------------------
// bdi_decompress
// Purely combinational reconstruction of a cache line from its encoded form.
// Decodes every code regardless of build options; unused codes 8-14 are
// treated as UNCOMP (pass-through).
// Ports:
//   CompressedCache   in  256  encoded payload
//   Encoding          in  4    encoding code
//   DeCompressedCache out 256  reconstructed line
// -----------------------------------------------------------------------------
module bdi_decompress
    import cc_pkg::*;
(
    input  logic [LINE_W-1:0] CompressedCache,
    input  logic [3:0]        Encoding,
    output logic [LINE_W-1:0] DeCompressedCache
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        DeCompressedCache = CompressedCache;
        case (Encoding)
            ENC_ZEROS: DeCompressedCache = '0;
            ENC_REP8:  DeCompressedCache = {4{CompressedCache[63:0]}};
            ENC_B8D1:  DeCompressedCache = bdi_unpack(CompressedCache, B8D1_X, B8D1_K);
            ENC_B4D1:  DeCompressedCache = bdi_unpack(CompressedCache, B4D1_X, B4D1_K);
            ENC_B8D2:  DeCompressedCache = bdi_unpack(CompressedCache, B8D2_X, B8D2_K);
            ENC_B2D1:  DeCompressedCache = bdi_unpack(CompressedCache, B2D1_X, B2D1_K);
            ENC_B4D2:  DeCompressedCache = bdi_unpack(CompressedCache, B4D2_X, B4D2_K);
            ENC_B8D4:  DeCompressedCache = bdi_unpack(CompressedCache, B8D4_X, B8D4_K);
            default:   DeCompressedCache = CompressedCache;
        endcase
    end

endmodule

// File: rtl/compressor_unit.sv
// -----------------------------------------------------------------------------
// compressor_unit
// Two-stage BDI cache line compressor with round-trip check output.
// Stage 1 registers the best (first-fitting) encoding of the input line,
// stage 2 registers the line rebuilt from that encoding. One line per cycle.
// Ports:
//   clock             in  1    rising-edge clock
//   reset_n           in  1    asynchronous active-low reset
//   UnCompressedCache in  256  line to compress, sampled every cycle
//   CompressedCache   out 256  registered encoded payload
//   Encoding          out 4    registered encoding code
//   DeCompressedCache out 256  registered reconstruction of CompressedCache
// Configuration: define CC_ZERO_REP_EN to enable ZEROS/REP8 detection;
// without it, priority starts at B8D1.
// -----------------------------------------------------------------------------
module compressor_unit
    import cc_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [LINE_W-1:0] UnCompressedCache,
    output logic [LINE_W-1:0] CompressedCache,
    output logic [3:0]        Encoding,
    output logic [LINE_W-1:0] DeCompressedCache
);

    bdi_t  w_b8d1, w_b4d1, w_b8d2, w_b2d1, w_b4d2, w_b8d4;
    enc_e  w_enc;
    line_t w_comp;
    line_t w_decomp;

    line_t r_comp;
    enc_e  r_enc;
    line_t r_decomp;

`ifdef CC_ZERO_REP_EN
    logic w_is_zero;
    logic w_is_rep8;

    assign w_is_zero = (UnCompressedCache == '0);
    assign w_is_rep8 = (UnCompressedCache[255:192] == UnCompressedCache[63:0]) &&
                       (UnCompressedCache[191:128] == UnCompressedCache[63:0]) &&
                       (UnCompressedCache[127:64]  == UnCompressedCache[63:0]);
`endif

    always_comb begin
        w_b8d1 = bdi_pack(UnCompressedCache, B8D1_X, B8D1_K);
        w_b4d1 = bdi_pack(UnCompressedCache, B4D1_X, B4D1_K);
        w_b8d2 = bdi_pack(UnCompressedCache, B8D2_X, B8D2_K);
        w_b2d1 = bdi_pack(UnCompressedCache, B2D1_X, B2D1_K);
        w_b4d2 = bdi_pack(UnCompressedCache, B4D2_X, B4D2_K);
        w_b8d4 = bdi_pack(UnCompressedCache, B8D4_X, B8D4_K);

        w_enc  = ENC_UNCOMP;
        w_comp = UnCompressedCache;
        if (w_b8d1.fit) begin
            w_enc  = ENC_B8D1;
            w_comp = w_b8d1.payload;
        end else if (w_b4d1.fit) begin
            w_enc  = ENC_B4D1;
            w_comp = w_b4d1.payload;
        end else if (w_b8d2.fit) begin
            w_enc  = ENC_B8D2;
            w_comp = w_b8d2.payload;
        end else if (w_b2d1.fit) begin
            w_enc  = ENC_B2D1;
            w_comp = w_b2d1.payload;
        end else if (w_b4d2.fit) begin
            w_enc  = ENC_B4D2;
            w_comp = w_b4d2.payload;
        end else if (w_b8d4.fit) begin
            w_enc  = ENC_B8D4;
            w_comp = w_b8d4.payload;
        end
`ifdef CC_ZERO_REP_EN
        // Evaluated after the BDI chain so that later assignments win:
        // ZEROS outranks REP8, which outranks every BxDk class.
        if (w_is_rep8) begin
            w_enc  = ENC_REP8;
            w_comp = {192'b0, UnCompressedCache[63:0]};
        end
        if (w_is_zero) begin
            w_enc  = ENC_ZEROS;
            w_comp = '0;
        end
`endif
    end

    bdi_decompress u_decompress (
        .CompressedCache   (r_comp),
        .Encoding          (r_enc),
        .DeCompressedCache (w_decomp)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_comp   <= '0;
            r_enc    <= ENC_ZEROS;
            r_decomp <= '0;
        end else begin
            // NOTE: registers use non-blocking assignment so both pipeline stages update from pre-edge values.
            r_comp   <= w_comp;
            r_enc    <= w_enc;
            r_decomp <= w_decomp;
        end
    end

    assign CompressedCache   = r_comp;
    assign Encoding          = r_enc;
    assign DeCompressedCache = r_decomp;

endmodule

// File: tb/tb_compressor_unit.sv
// -----------------------------------------------------------------------------
// tb_compressor_unit
// Self-checking bench for compressor_unit: a table of directed lines with
// known encodings, randomized lines checked against a byte-level reference
// model, and an asynchronous reset asserted mid-stream.
// Honours CC_ZERO_REP_EN for the expected ZEROS/REP8 behaviour.
// -----------------------------------------------------------------------------
module tb_compressor_unit;

    typedef logic [255:0] line_t;

    typedef struct {
        line_t      line;
        logic [3:0] exp_enc;
        bit         has_comp;
        line_t      exp_comp;
    } vec_t;

`ifdef CC_ZERO_REP_EN
    localparam logic [3:0] ZERO_ENC = 4'd0;
    localparam logic [3:0] REP_ENC  = 4'd1;
`else
    localparam logic [3:0] ZERO_ENC = 4'd2;
    localparam logic [3:0] REP_ENC  = 4'd2;
`endif

    logic       clock;
    logic       reset_n;
    line_t      UnCompressedCache;
    line_t      CompressedCache;
    logic [3:0] Encoding;
    line_t      DeCompressedCache;

    int    chk_cnt;
    int    pass_cnt;
    line_t h1;
    bit    h1_v;
    vec_t  vecs[14];

    compressor_unit dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .UnCompressedCache (UnCompressedCache),
        .CompressedCache   (CompressedCache),
        .Encoding          (Encoding),
        .DeCompressedCache (DeCompressedCache)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input line_t act, input line_t exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: try each class in priority order on whole-element integers.
    function automatic void model(input line_t line, output logic [3:0] enc, output line_t comp);
        int          xs[6]    = '{8, 4, 8, 2, 4, 8};
        int          ks[6]    = '{1, 1, 2, 1, 2, 4};
        int          codes[6] = '{2, 3, 4, 5, 6, 7};
        logic [63:0] e[32];
        longint      d[32];
        logic [7:0]  ob[32];
        bit          ok;
        enc  = 4'd15;
        comp = line;
`ifdef CC_ZERO_REP_EN
        if (line == '0) begin
            enc = 4'd0; comp = '0; return;
        end
        if (line[255:192] == line[63:0] && line[191:128] == line[63:0] && line[127:64] == line[63:0]) begin
            enc = 4'd1; comp = {192'b0, line[63:0]}; return;
        end
`endif
        for (int c = 0; c < 6; c++) begin
            int          x;
            int          k;
            int          n;
            longint      lim;
            logic [63:0] span;
            logic [63:0] diff;
            x   = xs[c];
            k   = ks[c];
            n   = 32 / x;
            lim = longint'(64'd1 << (8 * k - 1));
            ok  = 1'b1;
            for (int i = 0; i < n; i++) begin
                e[i] = '0;
                for (int j = 0; j < x; j++)
                    e[i] = e[i] | (64'(8'(line >> (8 * (x * i + j)))) << (8 * j));
            end
            for (int i = 0; i < n; i++) begin
                if (x == 8) d[i] = longint'(e[i] - e[0]);
                else begin
                    span = 64'd1 << (8 * x);
                    diff = (e[i] - e[0]) & (span - 64'd1);
                    d[i] = (diff >= span / 2) ? longint'(diff) - longint'(span) : longint'(diff);
                end
                if (d[i] < -lim || d[i] >= lim) ok = 1'b0;
            end
            if (ok) begin
                for (int j = 0; j < 32; j++) ob[j] = 8'h00;
                for (int j = 0; j < x; j++) ob[j] = 8'(e[0] >> (8 * j));
                for (int i = 0; i < n; i++)
                    for (int j = 0; j < k; j++)
                        ob[x + k * i + j] = 8'(d[i] >>> (8 * j));
                enc  = 4'(codes[c]);
                comp = '0;
                for (int j = 0; j < 32; j++) comp = comp | (line_t'(ob[j]) << (8 * j));
                return;
            end
        end
    endfunction

    // Random line biased towards compressible shapes and range boundaries.
    function automatic line_t gen();
        int          xs[6] = '{8, 4, 8, 2, 4, 8};
        int          ks[6] = '{1, 1, 2, 1, 2, 4};
        int          mode;
        int          c;
        int          pick;
        longint      lim;
        longint      d;
        logic [63:0] base;
        logic [63:0] e;
        line_t       l;
        l    = '0;
        mode = $urandom_range(0, 11);
        if (mode == 0) begin
            for (int w = 0; w < 8; w++) l = l | (line_t'($urandom) << (32 * w));
        end else if (mode == 1) begin
            l = '0;
        end else if (mode == 2) begin
            base = {$urandom, $urandom};
            l    = {4{base}};
        end else begin
            c    = $urandom_range(0, 5);
            base = {$urandom, $urandom};
            lim  = longint'(64'd1 << (8 * ks[c] - 1));
            for (int i = 0; i < 32 / xs[c]; i++) begin
                pick = $urandom_range(0, 9);
                if (i == 0)         d = 0;
                else if (pick == 0) d = longint'({$urandom, $urandom});
                else if (pick == 1) d = -lim;
                else if (pick == 2) d = lim - 1;
                else                d = (longint'({32'b0, $urandom}) % (2 * lim)) - lim;
                e = base + 64'(d);
                for (int j = 0; j < xs[c]; j++)
                    l = l | (line_t'(8'(e >> (8 * j))) << (8 * (xs[c] * i + j)));
            end
        end
        return l;
    endfunction

    // Drive one line, then after the edge compare stage 1 with the model and
    // stage 2 with the line driven on the previous cycle.
    task automatic step(input line_t line, input string tag);
        logic [3:0] e_enc;
        line_t      e_comp;
        @(negedge clock);
        UnCompressedCache = line;
        @(posedge clock);
        #1;
        model(line, e_enc, e_comp);
        check({tag, " enc"}, line_t'(Encoding), line_t'(e_enc));
        check({tag, " comp"}, CompressedCache, e_comp);
        if (h1_v) check({tag, " decomp"}, DeCompressedCache, h1);
        h1   = line;
        h1_v = 1'b1;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        h1       = '0;
        h1_v     = 1'b0;
        reset_n  = 1'b1;
        UnCompressedCache = '0;

        vecs[0]  = '{{64'h66, 64'h44, 64'h22, 64'hFF}, 4'd4, 1'b1,
                     {128'b0, 16'hFF67, 16'hFF45, 16'hFF23, 16'h0000, 64'hFF}};
        vecs[1]  = '{{64'h5566, 64'h3344, 64'h1122, 64'h0}, 4'd4, 1'b0, '0};
        vecs[2]  = '{{32'h88, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h0}, 4'd6, 1'b0, '0};
        vecs[3]  = '{{32'h7788, 32'h6677, 32'h5566, 32'h4455, 32'h3344, 32'h2233, 32'h1122, 32'h0},
                     4'd6, 1'b0, '0};
        vecs[4]  = '{{16'h85, 16'h80, 16'h70, 16'h68, 16'h60, 16'h58, 16'h50, 16'h48,
                      16'h40, 16'h38, 16'h30, 16'h28, 16'h20, 16'h18, 16'h10, 16'h0}, 4'd15, 1'b0, '0};
        vecs[5]  = '{{16'h7F, 16'h7E, 16'h70, 16'h68, 16'h60, 16'h58, 16'h50, 16'h48,
                      16'h40, 16'h38, 16'h30, 16'h28, 16'h20, 16'h18, 16'h10, 16'h0}, 4'd5, 1'b0, '0};
        vecs[6]  = '{'0, ZERO_ENC, 1'b0, '0};
        vecs[7]  = '{{4{64'hDEADBEEF}}, REP_ENC, 1'b0, '0};
        vecs[8]  = '{{64'h1001, 64'h0F80, 64'h107F, 64'h1000}, 4'd2, 1'b0, '0};
        vecs[9]  = '{{64'h1001, 64'h0F80, 64'h1080, 64'h1000}, 4'd4, 1'b0, '0};
        vecs[10] = '{{32'h107, 32'h106, 32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100},
                     4'd3, 1'b0, '0};
        vecs[11] = '{{64'h2, 64'h1, 64'h7FFFFFFF, 64'h0}, 4'd7, 1'b0, '0};
        vecs[12] = '{{64'h2, 64'h1, 64'hFFFFFFFF80000000, 64'h0}, 4'd7, 1'b0, '0};
        vecs[13] = '{{64'h2, 64'h1, 64'h80000000, 64'h0}, 4'd15, 1'b0, '0};

        // Asynchronous reset before any clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("reset comp", CompressedCache, '0);
        check("reset enc", line_t'(Encoding), '0);
        check("reset decomp", DeCompressedCache, '0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        h1   = '0;
        h1_v = 1'b1;

        for (int v = 0; v < 14; v++) begin
            step(vecs[v].line, $sformatf("vec%0d", v));
            check($sformatf("vec%0d table enc", v), line_t'(Encoding), line_t'(vecs[v].exp_enc));
            if (vecs[v].has_comp)
                check($sformatf("vec%0d table comp", v), CompressedCache, vecs[v].exp_comp);
        end

        for (int r = 0; r < 300; r++) begin
            step(gen(), $sformatf("rnd%0d", r));
            if (r == 150) begin
                // Reset mid-stream: outputs clear at once and stay clear across an edge.
                #2 reset_n = 1'b0;
                #1;
                check("midreset comp", CompressedCache, '0);
                check("midreset enc", line_t'(Encoding), '0);
                check("midreset decomp", DeCompressedCache, '0);
                @(posedge clock);
                #1;
                check("held reset comp", CompressedCache, '0);
                check("held reset decomp", DeCompressedCache, '0);
                #1 reset_n = 1'b1;
                h1   = '0;
                h1_v = 1'b1;
            end
        end
        step('0, "flush");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/compressor_unit.md
COMPRESSOR_UNIT -- requirements
Module: compressor_unit

Interface
REQ-001 SHALL have port: clock  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: UnCompressedCache  input  256  cache line to compress, sampled every cycle.
REQ-004 SHALL have port: CompressedCache  output  256  registered encoded line.
REQ-005 SHALL have port: Encoding  output  4  registered encoding code for CompressedCache.
REQ-006 SHALL have port: DeCompressedCache  output  256  registered line reconstructed from CompressedCache/Encoding.

Function
REQ-007 SHALL use these Encoding codes:
- 0 ZEROS
- 1 REP8
- 2 B8D1
- 3 B4D1
- 4 B8D2
- 5 B2D1
- 6 B4D2
- 7 B8D4
- 15 UNCOMP
- 8-14 unused
REQ-008 SHALL, for BxDk, split the line into 256/(8x) elements of x bytes, element 0 at bits [8x-1:0], with base = element 0.
REQ-009 SHALL compute delta_i = element_i - base mod 2^(8x); a class fits only if every delta_i lies in signed k-byte range [-2^(8k-1), 2^(8k-1)-1].
REQ-010 SHALL pack BxDk payload as base in bits [8x-1:0], then delta_i (i=0..n-1, k bytes each) at [8x+8k*i +: 8k], remaining bits zero.
- Payload sizes: B8D1 96, B4D1 96, B8D2 128, B2D1 144, B4D2 160, B8D4 192.
REQ-011 SHALL output ZEROS with CompressedCache=0 when the line is all zero.
REQ-012 SHALL output REP8 with CompressedCache={192'b0, word0} when all four 64-bit words are equal.
REQ-013 SHALL select the first fitting class in priority ZEROS, REP8, B8D1, B4D1, B8D2, B2D1, B4D2, B8D4, UNCOMP; UNCOMP passes the line through unchanged.
REQ-014 SHALL register CompressedCache/Encoding 1 cycle after UnCompressedCache is sampled.
REQ-015 SHALL register DeCompressedCache one cycle after CompressedCache, giving 2-cycle total latency and one new line per cycle.
REQ-016 SHALL reconstruct element_i = base + sign_extend(delta_i), truncated to 8x bits; ZEROS gives 0; REP8 replicates word0; UNCOMP gives CompressedCache.
REQ-017 SHALL decode unused codes 8-14 as UNCOMP.
REQ-018 SHALL guarantee DeCompressedCache equals the UnCompressedCache sampled two edges earlier.

Reset
REQ-019 SHALL, while reset_n=0, asynchronously force CompressedCache=0, Encoding=0 (ZEROS) and DeCompressedCache=0.
REQ-020 SHALL discard any line in flight when reset asserts mid-operation, and restart 2-cycle latency from the first edge after deassertion.

Configuration
REQ-021 SHALL gate ZEROS and REP8 detection with macro CC_ZERO_REP_EN.
- Defined: ZEROS/REP8 detection enabled.
- Undefined: those codes are never produced, and priority starts at B8D1, so all-zero lines encode as B8D1 with zero payload.
- Decompressor SHALL decode all codes in both builds.

Structure
REQ-022 SHALL place the Encoding code constants, element/delta widths and payload sizes in shared package cc_pkg.
REQ-023 SHALL implement reconstruction in one sub-module bdi_decompress (combinational; inputs CompressedCache and Encoding; output 256-bit line), registered by the parent.

Verification
REQ-024 Four 64-bit words {0x66,0x44,0x22,0xFF} (word3..word0) -> Encoding=4 (B8D2), CompressedCache[191:0]={16'h... deltas FF67,FF45,FF23,0000 above base 0xFF}, DeCompressedCache equals input two edges later.
REQ-025 Words {0x5566,0x3344,0x1122,0} -> Encoding=4 (B8D2), base 0, deltas 0,0x1122,0x3344,0x5566.
REQ-026 32-bit elements {0x88,0x77,...,0x22,0} -> Encoding=6 (B4D2), since 0x88 exceeds the signed 8-bit range; {0x7788,...,0x1122,0} -> Encoding=6 (B4D2).
REQ-027 16-bit elements {0x85,0x80,...,0x10,0} -> Encoding=15 (UNCOMP) with CompressedCache equal to the input; the same line with 0x85/0x80 replaced by 0x7F/0x7E -> Encoding=5 (B2D1).
REQ-028 All-zero line -> Encoding=0 with CC_ZERO_REP_EN defined, Encoding=2 when undefined; line of four words 0xDEADBEEF -> Encoding=1 (REP8).
REQ-029 Assert reset_n=0 during back-to-back line streaming -> all outputs 0 immediately; after release, roundtrip resumes with 2-cycle latency.
